// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 constants, helper functions and controller state
// encoding for sha256_stream_core and sha256_round.
//   K[0:63]  round constants
//   IV[0:7]  standard initial chaining value
//   rotr, big_sigma0/1, small_sigma0/1, ch, maj  round/schedule helpers
//   state_e  controller states
package sha256_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BLK,
    ST_COMPUTE,
    ST_UPDATE,
    ST_OUTPUT
  } state_e;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 compression round.
//   st_i  working variables a..h (index 0 = a, 7 = h)
//   w_i   schedule word for this round
//   k_i   round constant for this round
//   st_o  working variables after the round
module sha256_round
  import sha256_pkg::*;
(
  input  logic [7:0][31:0] st_i,
  input  logic [31:0]      w_i,
  input  logic [31:0]      k_i,
  output logic [7:0][31:0] st_o
);

  logic [31:0] t1;
  logic [31:0] t2;

  always_comb begin
    t1 = st_i[7] + big_sigma1(st_i[4]) + ch(st_i[4], st_i[5], st_i[6]) + k_i + w_i;
    t2 = big_sigma0(st_i[0]) + maj(st_i[0], st_i[1], st_i[2]);
    st_o[0] = t1 + t2;
    st_o[1] = st_i[0];
    st_o[2] = st_i[1];
    st_o[3] = st_i[2];
    st_o[4] = st_i[3] + t1;
    st_o[5] = st_i[4];
    st_o[6] = st_i[5];
    st_o[7] = st_i[6];
  end

endmodule

// File: rtl/sha256_stream_core.sv
// sha256_stream_core: block-streaming SHA-256 compression engine (no padding).
// Optional feature macro: SHA256_MIDSTATE_EN (adds init_hash, start loads it
// instead of the standard IV).
//   clk, reset          clock, synchronous active-high reset
//   start               begin new message (IDLE only)
//   blk_valid/ready     block handshake; blk_last marks final block
//   blk_data            16 message words, word 0 at index 0
//   init_hash           initial chaining value (SHA256_MIDSTATE_EN only)
//   hash_valid/ready    digest handshake; hash_out H0..H7 at index 0..7
//   blk_count           saturating count of blocks absorbed
//   busy                high outside IDLE
//
// state      | meaning
// IDLE       | waiting for start, holds last digest
// WAIT_BLK   | blk_ready high, waiting for a block
// COMPUTE    | ROUNDS_PER_CYCLE rounds per cycle, 64 rounds total
// UPDATE     | fold working vars into chaining hash, bump blk_count
// OUTPUT     | digest presented until hash_ready
module sha256_stream_core
  import sha256_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int BLK_CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 blk_valid,
  output logic                 blk_ready,
  input  logic                 blk_last,
  input  logic [15:0][31:0]    blk_data,
`ifdef SHA256_MIDSTATE_EN
  input  logic [7:0][31:0]     init_hash,
`endif
  output logic                 hash_valid,
  input  logic                 hash_ready,
  output logic [7:0][31:0]     hash_out,
  output logic [BLK_CNT_W-1:0] blk_count,
  output logic                 busy
);

  localparam int R = ROUNDS_PER_CYCLE;

  generate
    if (!(R == 1 || R == 2 || R == 4)) begin : g_bad_rpc
      $error("sha256_stream_core: ROUNDS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  state_e                 state_q;
  logic [7:0][31:0]       h_q;
  logic [7:0][31:0]       wv_q;
  logic [15:0][31:0]      w_q;
  logic [15:0][31:0]      w_d;
  logic [5:0]             rnd_q;
  logic                   last_q;
  logic [BLK_CNT_W-1:0]   cnt_q;
  logic                   blk_ready_q;
  logic                   hash_valid_q;
  logic                   busy_q;

  // w_q holds W[t..t+15] where t is the first round of this cycle; ext
  // extends it by the R words needed to slide the window forward.
  logic [31:0]            ext [0:15+R];
  logic [7:0][31:0]       rs  [0:R];

  always_comb begin
    for (int i = 0; i < 16; i++) ext[i] = w_q[i];
    for (int j = 0; j < R; j++) begin
      ext[16+j] = small_sigma1(ext[14+j]) + ext[9+j] + small_sigma0(ext[1+j]) + ext[j];
    end
    for (int i = 0; i < 16; i++) w_d[i] = ext[i+R];
  end

  assign rs[0] = wv_q;

  generate
    for (genvar g = 0; g < R; g++) begin : g_rnd
      sha256_round u_rnd (
        .st_i (rs[g]),
        .w_i  (ext[g]),
        .k_i  (K[rnd_q + 6'(g)]),
        .st_o (rs[g+1])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      h_q          <= '0;
      cnt_q        <= '0;
      blk_ready_q  <= 1'b0;
      hash_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
`ifdef SHA256_MIDSTATE_EN
            h_q <= init_hash;
`else
            for (int i = 0; i < 8; i++) h_q[i] <= IV[i];
`endif
            cnt_q       <= '0;
            blk_ready_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ST_WAIT_BLK;
          end
        end
        ST_WAIT_BLK: begin
          if (blk_valid) begin
            w_q         <= blk_data;
            last_q      <= blk_last;
            wv_q        <= h_q;
            rnd_q       <= '0;
            blk_ready_q <= 1'b0;
            state_q     <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          wv_q  <= rs[R];
          w_q   <= w_d;
          rnd_q <= rnd_q + 6'(R);
          if (rnd_q == 6'(64 - R)) state_q <= ST_UPDATE;
        end
        ST_UPDATE: begin
          for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + wv_q[i];
          if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
          if (last_q) begin
            hash_valid_q <= 1'b1;
            state_q      <= ST_OUTPUT;
          end else begin
            blk_ready_q <= 1'b1;
            state_q     <= ST_WAIT_BLK;
          end
        end
        ST_OUTPUT: begin
          if (hash_ready) begin
            hash_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign blk_ready  = blk_ready_q;
  assign hash_valid = hash_valid_q;
  assign hash_out   = h_q;
  assign blk_count  = cnt_q;
  assign busy       = busy_q;

endmodule

// File: doc/sha256_stream_core.md
SHA256_STREAM_CORE -- requirements
Module: sha256_stream_core

Interface
REQ-001 SHALL have parameter ROUNDS_PER_CYCLE, default 1, rounds evaluated per compute cycle; legal 1, 2, 4; other values SHALL fail elaboration.
REQ-002 SHALL have parameter BLK_CNT_W, default 16, width of the per-message block counter.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins a new message; honoured only in IDLE.
REQ-006 blk_valid  input  1  block word set valid.
REQ-007 blk_ready  output  1  core accepts a block this cycle.
REQ-008 blk_last  input  1  qualifies blk_valid; the block is the final block of the message.
REQ-009 blk_data  input  32x16  message words w[0..15], word 0 first in SHA-256 order.
REQ-010 init_hash  input  32x8  initial chaining value; used only under SHA256_MIDSTATE_EN.
REQ-011 hash_valid  output  1  digest available.
REQ-012 hash_ready  input  1  consumer accepts digest.
REQ-013 hash_out  output  32x8  digest H0..H7.
REQ-014 blk_count  output  BLK_CNT_W  blocks absorbed in current/last message.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 States SHALL be IDLE, WAIT_BLK, COMPUTE, UPDATE, OUTPUT.
REQ-017 IDLE: start SHALL load chaining hash (IV or init_hash), clear blk_count, go WAIT_BLK next cycle.
REQ-018 WAIT_BLK: blk_ready SHALL be 1; on blk_valid&blk_ready, SHALL capture blk_data, blk_last, load a..h from chaining hash, clear round index, go COMPUTE.
REQ-019 blk_ready SHALL be 0 in every state except WAIT_BLK.
REQ-020 COMPUTE: each cycle SHALL apply ROUNDS_PER_CYCLE rounds with on-the-fly 16-word schedule window; after round 63 SHALL go UPDATE; COMPUTE lasts exactly 64/ROUNDS_PER_CYCLE cycles.
REQ-021 UPDATE: chaining hash SHALL become H[i]+working[i] mod 2^32, blk_count SHALL increment; next state OUTPUT if captured blk_last, else WAIT_BLK.
REQ-022 Block latency (accept to UPDATE exit) SHALL be 64/ROUNDS_PER_CYCLE+1 cycles.
REQ-023 OUTPUT: hash_valid SHALL be 1 and hash_out stable until hash_valid&hash_ready; then IDLE next cycle.
REQ-024 hash_out SHALL hold last digest in IDLE; hash_valid SHALL be 0 outside OUTPUT.
REQ-025 start outside IDLE SHALL be ignored; start and blk_valid in same IDLE cycle: block not accepted.
REQ-026 blk_count SHALL saturate at all-ones, hashing unaffected.
REQ-027 Core SHALL NOT pad; caller supplies padded blocks.
REQ-028 All additions SHALL be 32-bit modulo 2^32; rotations per FIPS 180-4.

Reset
REQ-029 reset SHALL force IDLE, blk_ready 0, hash_valid 0, busy 0, blk_count 0, hash_out 0, overriding any in-flight block.
REQ-030 First cycle after reset deasserts SHALL accept start.

Configuration
REQ-031 With SHA256_MIDSTATE_EN defined, start SHALL load init_hash; init_hash port present.
REQ-032 Without SHA256_MIDSTATE_EN, start SHALL load FIPS 180-4 IV 6a09e667..5be0cd19; init_hash port absent.

Structure
REQ-033 Package sha256_pkg SHALL hold K[0:63], IV[0:7], rotr, Sigma0/1, sigma0/1, ch, maj, and state enum.
REQ-034 Sub-module sha256_round SHALL be one combinational round (a..h, w, k -> a..h), instanced ROUNDS_PER_CYCLE times in chain.

Verification
REQ-035 "abc" padded, 1 block, blk_last=1 -> hash_out ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, blk_count 1.
REQ-036 Empty message padded (80000000, zeros) -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
REQ-037 "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", 2 blocks, gap of 5 idle cycles between -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1, blk_count 2.
REQ-038 REQ-035 with hash_ready low 10 cycles -> hash_valid held, hash_out stable, then IDLE one cycle after handshake; repeat for ROUNDS_PER_CYCLE 1, 2, 4 with latency 65/33/17.
REQ-039 reset pulsed mid-COMPUTE of block 2 -> all outputs at reset values next cycle; fresh "abc" run gives REQ-035 digest.
REQ-040 SHA256_MIDSTATE_EN, init_hash = digest of block 1 of REQ-037, feed block 2 only -> REQ-037 digest, blk_count 1.
